// File: rtl/hb_decim.sv
// Half-band decimate-by-2 FIR with a serial MAC, valid/ready handshakes, bypass and output saturation.
// Build option: define HB_DECIM_ROUND_EN for round-half-up scaling; otherwise the result is truncated.
module hb_decim #(
  parameter int                   DW      = 35,
  parameter int                   CW      = 31,
  parameter int                   NPAIR   = 2,
  parameter int                   SHIFT   = 30,
  parameter logic [NPAIR*CW-1:0]  COEF    = {31'sd316817548, -31'sd54357298},
  parameter logic signed [CW-1:0] CCENTER = CW'(536870912)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic signed [DW-1:0] in_dat,
  input  logic                 bypass,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic signed [DW-1:0] out_dat,
  output logic                 ovf
);

  localparam int PW  = DW + 1;
  localparam int PRW = DW + CW + 1;
  localparam int AW  = PRW + $clog2(NPAIR + 1);
  localparam int AW1 = AW + 1;
  localparam int KW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_CTR  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]                 state_q, state_d;
  logic                       phase_q, phase_d;
  logic [KW-1:0]              k_q, k_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic signed [DW-1:0]       e_q [2*NPAIR];
  logic signed [DW-1:0]       d_q [NPAIR];
  logic                       out_vld_q, out_vld_d;
  logic                       ovf_q, ovf_d;
  logic signed [DW-1:0]       out_dat_q, out_dat_d;
  logic                       shift_e, shift_d;
  logic signed [DW-1:0]       e_lo, e_hi;
  logic signed [CW-1:0]       coef_k;
  logic signed [PW-1:0]       pair_sum;
  logic signed [PRW-1:0]      prod;
  logic signed [AW-1:0]       ctr_prod;

  function automatic logic signed [AW:0] scale(input logic signed [AW-1:0] a);
    logic signed [AW:0] ext;
    ext = AW1'(a);
`ifdef HB_DECIM_ROUND_EN
    // One extra bit of headroom keeps the rounding offset from wrapping.
    ext = ext + (AW1'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) * AW1'((SHIFT > 0) ? 1 : 0);
`endif
    return ext >>> SHIFT;
  endfunction

  function automatic logic [DW:0] saturate(input logic signed [AW:0] r);
    if (r > AW1'(DMAX))      return {1'b1, DMAX};
    else if (r < AW1'(DMIN)) return {1'b1, DMIN};
    else                     return {1'b0, r[DW-1:0]};
  endfunction

  assign in_rdy  = (state_q == S_IDLE);
  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign ovf     = ovf_q;

  // MAC operand select: pair k folds the k-th newest and k-th oldest even samples
  always_comb begin
    e_lo   = '0;
    e_hi   = '0;
    coef_k = '0;
    for (int i = 0; i < NPAIR; i++) begin
      if (k_q == KW'(i)) begin
        e_lo   = e_q[i];
        e_hi   = e_q[2*NPAIR-1-i];
        coef_k = COEF[i*CW +: CW];
      end
    end
    pair_sum = PW'(e_lo) + PW'(e_hi);
    prod     = PRW'(pair_sum) * PRW'(coef_k);
    ctr_prod = AW'(d_q[NPAIR-1]) * AW'(CCENTER);
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    k_d       = k_q;
    acc_d     = acc_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    ovf_d     = ovf_q;
    shift_e   = 1'b0;
    shift_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          if (bypass) begin
            out_dat_d = in_dat;
            ovf_d     = 1'b0;
            out_vld_d = 1'b1;
            phase_d   = 1'b0;
            state_d   = S_OUT;
          end else if (!phase_q) begin
            shift_e = 1'b1;
            phase_d = 1'b1;
          end else begin
            shift_d = 1'b1;
            phase_d = 1'b0;
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NPAIR-1)) state_d = S_CTR;
      end
      S_CTR: begin
        acc_d                = acc_q + ctr_prod;
        {ovf_d, out_dat_d}   = saturate(scale(acc_d));
        out_vld_d            = 1'b1;
        state_d              = S_OUT;
      end
      S_OUT: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: control, accumulator, delay lines and output holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      k_q       <= '0;
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 2*NPAIR; i++) e_q[i] <= '0;
      for (int i = 0; i < NPAIR; i++)   d_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      ovf_q     <= ovf_d;
      if (shift_e) begin
        e_q[0] <= in_dat;
        for (int i = 1; i < 2*NPAIR; i++) e_q[i] <= e_q[i-1];
      end
      if (shift_d) begin
        d_q[0] <= in_dat;
        for (int i = 1; i < NPAIR; i++) d_q[i] <= d_q[i-1];
      end
    end
  end

endmodule
